// File: rtl/ahb_lite_decoder_mux_if.sv
// rtl/ahb_lite_decoder_mux_if.sv - bus bundle between the AHB-Lite manager, subordinates and the decoder/mux
interface ahb_lite_decoder_mux_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   HADDR;
   logic [1:0]              HTRANS;
   logic [3:0]              HSEL_S;
   logic                    HSEL_DEF;
   logic [4*DATA_WIDTH-1:0] HRDATA_S;
   logic [7:0]              HRESP_S;
   logic [3:0]              HREADYOUT_S;
   logic [DATA_WIDTH-1:0]   HRDATA_DEF;
   logic [1:0]              HRESP_DEF;
   logic                    HREADYOUT_DEF;
   logic [DATA_WIDTH-1:0]   HRDATA;
   logic [1:0]              HRESP;
   logic                    HREADY;
   logic [15:0]             MISS_CNT;

   modport slave (
      input  HADDR, HTRANS,
      input  HRDATA_S, HRESP_S, HREADYOUT_S,
      input  HRDATA_DEF, HRESP_DEF, HREADYOUT_DEF,
      output HSEL_S, HSEL_DEF,
      output HRDATA, HRESP, HREADY, MISS_CNT
   );

   modport master (
      output HADDR, HTRANS,
      output HRDATA_S, HRESP_S, HREADYOUT_S,
      output HRDATA_DEF, HRESP_DEF, HREADYOUT_DEF,
      input  HSEL_S, HSEL_DEF,
      input  HRDATA, HRESP, HREADY, MISS_CNT
   );
endinterface

// File: rtl/ahb_lite_decoder_mux.sv
// rtl/ahb_lite_decoder_mux.sv - AHB-Lite address decoder, data-phase owner register and response mux
module ahb_lite_decoder_mux #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    REGION_BITS = 12,
   parameter logic [ADDR_WIDTH-1:0] S0_BASE     = 32'h0000_0000,
   parameter logic [ADDR_WIDTH-1:0] S1_BASE     = 32'h0000_1000,
   parameter logic [ADDR_WIDTH-1:0] S2_BASE     = 32'h0000_2000,
   parameter logic [ADDR_WIDTH-1:0] S3_BASE     = 32'h0000_3000
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   ahb_lite_decoder_mux_if.slave bus
);

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_S0,
      SEL_S1,
      SEL_S2,
      SEL_S3,
      SEL_DEF
   } dsel_e;

   dsel_e                 dsel_q;
   dsel_e                 dsel_d;
   dsel_e                 dsel_addr;
   logic [3:0]            hit;
   logic [3:0]            sel_s;
   logic                  sel_def;
   logic [DATA_WIDTH-1:0] hrdata;
   logic [1:0]            hresp;
   logic                  hready;
   logic [15:0]           miss_cnt;

   assign hit[0] = bus.HADDR[ADDR_WIDTH-1:REGION_BITS] == S0_BASE[ADDR_WIDTH-1:REGION_BITS];
   assign hit[1] = bus.HADDR[ADDR_WIDTH-1:REGION_BITS] == S1_BASE[ADDR_WIDTH-1:REGION_BITS];
   assign hit[2] = bus.HADDR[ADDR_WIDTH-1:REGION_BITS] == S2_BASE[ADDR_WIDTH-1:REGION_BITS];
   assign hit[3] = bus.HADDR[ADDR_WIDTH-1:REGION_BITS] == S3_BASE[ADDR_WIDTH-1:REGION_BITS];

   // Lowest index wins on overlap; the error responder only sees real transfers.
   always_comb begin
      sel_s     = 4'b0000;
      dsel_addr = SEL_NONE;
      sel_def   = 1'b0;
      if (hit[0]) begin
         sel_s     = 4'b0001;
         dsel_addr = SEL_S0;
      end else if (hit[1]) begin
         sel_s     = 4'b0010;
         dsel_addr = SEL_S1;
      end else if (hit[2]) begin
         sel_s     = 4'b0100;
         dsel_addr = SEL_S2;
      end else if (hit[3]) begin
         sel_s     = 4'b1000;
         dsel_addr = SEL_S3;
      end else if (bus.HTRANS[1]) begin
         sel_def   = 1'b1;
         dsel_addr = SEL_DEF;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dsel_q <= SEL_NONE;
      end else begin
         dsel_q <= dsel_d;
      end
   end

   always_comb begin
      dsel_d = dsel_q;
      if (hready) begin
         dsel_d = dsel_addr;
      end
   end

   always_comb begin
      hrdata = '0;
      hresp  = 2'b00;
      hready = 1'b1;
      case (dsel_q)
         SEL_S0: begin
            hrdata = bus.HRDATA_S[0*DATA_WIDTH +: DATA_WIDTH];
            hresp  = bus.HRESP_S[1:0];
            hready = bus.HREADYOUT_S[0];
         end
         SEL_S1: begin
            hrdata = bus.HRDATA_S[1*DATA_WIDTH +: DATA_WIDTH];
            hresp  = bus.HRESP_S[3:2];
            hready = bus.HREADYOUT_S[1];
         end
         SEL_S2: begin
            hrdata = bus.HRDATA_S[2*DATA_WIDTH +: DATA_WIDTH];
            hresp  = bus.HRESP_S[5:4];
            hready = bus.HREADYOUT_S[2];
         end
         SEL_S3: begin
            hrdata = bus.HRDATA_S[3*DATA_WIDTH +: DATA_WIDTH];
            hresp  = bus.HRESP_S[7:6];
            hready = bus.HREADYOUT_S[3];
         end
         SEL_DEF: begin
            hrdata = bus.HRDATA_DEF;
            hresp  = bus.HRESP_DEF;
            hready = bus.HREADYOUT_DEF;
         end
         default: begin
         end
      endcase
   end

   // Saturating so a long-running debug session never reads a small wrapped value.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         miss_cnt <= 16'h0000;
      end else if (hready && sel_def && (miss_cnt != 16'hFFFF)) begin
         miss_cnt <= miss_cnt + 16'd1;
      end
   end

   assign bus.HSEL_S   = sel_s;
   assign bus.HSEL_DEF = sel_def;
   assign bus.HRDATA   = hrdata;
   assign bus.HRESP    = hresp;
   assign bus.HREADY   = hready;
   assign bus.MISS_CNT = miss_cnt;

endmodule

// File: tb/tb_ahb_lite_decoder_mux.sv
// tb/tb_ahb_lite_decoder_mux.sv - scoreboard bench for ahb_lite_decoder_mux
module tb_ahb_lite_decoder_mux;

   localparam logic [1:0]   IDLE     = 2'b00;
   localparam logic [1:0]   BUSY     = 2'b01;
   localparam logic [1:0]   NONSEQ   = 2'b10;
   localparam logic [1:0]   SEQ      = 2'b11;
   localparam int           T_NONE   = 4;
   localparam int           T_DEF    = 5;
   localparam logic [127:0] SUB_DATA = {32'h3333_CAFE, 32'hDEAD_BEEF, 32'h2222_1111, 32'h1111_0000};
   localparam logic [31:0]  DEF_DATA = 32'hBAD0_BAD0;

   typedef struct {
      string       tag;
      int          tgt;
      logic [31:0] rdata;
      logic [1:0]  resp;
      int          waits;
   } item_t;

   logic  HCLK;
   logic  HRESETn;
   item_t exp_q[$];
   int    n_checks = 0;
   int    n_errors = 0;
   bit    have_addr = 1'b0;
   bit    timed_out = 1'b0;

   bit    inflight = 1'b0;
   int    wait_cnt = 0;
   int    dp_tgt   = T_NONE;
   int    dp_waits = 0;
   bit    n_inflight = 1'b0;
   int    n_wait     = 0;
   int    n_tgt      = T_NONE;
   int    n_waits    = 0;

   ahb_lite_decoder_mux_if bus ();
   ahb_lite_decoder_mux_if bus2 ();

   ahb_lite_decoder_mux dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .bus     (bus)
   );

   ahb_lite_decoder_mux #(
      .S1_BASE (32'h0000_0000)
   ) dut_ovl (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .bus     (bus2)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   // Subordinate models: every one drives distinct data, only the owner of the
   // bench's own data phase inserts its wait states.
   assign bus.HRDATA_S   = SUB_DATA;
   assign bus.HRESP_S    = 8'h00;
   assign bus.HRDATA_DEF = DEF_DATA;
   assign bus.HRESP_DEF  = 2'b01;
   always_comb begin
      for (int n = 0; n < 4; n++) begin
         bus.HREADYOUT_S[n] = !(inflight && dp_tgt == n && wait_cnt < dp_waits);
      end
      bus.HREADYOUT_DEF = !(inflight && dp_tgt == T_DEF && wait_cnt < dp_waits);
   end

   assign bus2.HRDATA_S      = {32'h5353_3333, 32'h5252_2222, 32'h5151_1111, 32'h5050_0000};
   assign bus2.HRESP_S       = 8'h00;
   assign bus2.HREADYOUT_S   = 4'hF;
   assign bus2.HRDATA_DEF    = 32'h0;
   assign bus2.HRESP_DEF     = 2'b01;
   assign bus2.HREADYOUT_DEF = 1'b1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge HCLK) begin
      item_t it;
      if (!HRESETn) begin
         exp_q.delete();
         n_inflight = 1'b0;
         n_wait     = 0;
         n_tgt      = T_NONE;
         n_waits    = 0;
      end else begin
         n_inflight = inflight;
         n_wait     = wait_cnt;
         n_tgt      = dp_tgt;
         n_waits    = dp_waits;
         if (inflight && exp_q.size() > 0) begin
            if (!bus.HREADY) begin
               chk({exp_q[0].tag, "_wait_hresp"}, 32'(bus.HRESP), 32'(exp_q[0].resp));
               n_wait = wait_cnt + 1;
            end else begin
               it = exp_q.pop_front();
               chk({it.tag, "_hrdata"}, bus.HRDATA, it.rdata);
               chk({it.tag, "_hresp"}, 32'(bus.HRESP), 32'(it.resp));
               chk({it.tag, "_waits"}, 32'(wait_cnt), 32'(it.waits));
               n_inflight = 1'b0;
            end
         end
         if (bus.HREADY && have_addr && exp_q.size() > 0) begin
            n_inflight = 1'b1;
            n_wait     = 0;
            n_tgt      = exp_q[$].tgt;
            n_waits    = exp_q[$].waits;
         end
      end
   end

   always @(posedge HCLK) begin
      if (!HRESETn) begin
         inflight <= 1'b0;
         wait_cnt <= 0;
         dp_tgt   <= T_NONE;
         dp_waits <= 0;
      end else begin
         inflight <= n_inflight;
         wait_cnt <= n_wait;
         dp_tgt   <= n_tgt;
         dp_waits <= n_waits;
      end
   end

   task automatic beat(input string tag, input logic [31:0] addr, input logic [1:0] trans, input int waits);
      item_t        it;
      logic [127:0] sd;
      logic [3:0]   exp_sel;
      int           region;
      int           n;
      bit           rdy;
      sd       = SUB_DATA;
      region   = int'(addr[31:12]);
      exp_sel  = 4'b0000;
      it.tag   = tag;
      it.waits = waits;
      if (region < 4) begin
         it.tgt          = region;
         it.rdata        = sd[region*32 +: 32];
         it.resp         = 2'b00;
         exp_sel[region] = 1'b1;
      end else if (trans[1]) begin
         it.tgt   = T_DEF;
         it.rdata = DEF_DATA;
         it.resp  = 2'b01;
      end else begin
         it.tgt   = T_NONE;
         it.rdata = 32'h0;
         it.resp  = 2'b00;
         it.waits = 0;
      end
      bus.HADDR  = addr;
      bus.HTRANS = trans;
      exp_q.push_back(it);
      have_addr = 1'b1;
      #1;
      chk({tag, "_hsel_s"}, 32'(bus.HSEL_S), 32'(exp_sel));
      chk({tag, "_hsel_def"}, 32'(bus.HSEL_DEF), 32'(it.tgt == T_DEF));
      n   = 0;
      rdy = 1'b0;
      while (!rdy && n < 64) begin
         @(negedge HCLK);
         rdy = bus.HREADY;
         @(posedge HCLK);
         #1;
         n++;
      end
      if (!rdy) begin
         timed_out = 1'b1;
         chk({tag, "_accept_timeout"}, 32'(rdy), 32'd1);
      end
   endtask

   initial begin
      HRESETn     = 1'b0;
      bus.HADDR   = 32'h0000_3000;
      bus.HTRANS  = NONSEQ;
      bus2.HADDR  = 32'h0000_0010;
      bus2.HTRANS = NONSEQ;
      #12;
      chk("rst_hready", 32'(bus.HREADY), 32'd1);
      chk("rst_hresp", 32'(bus.HRESP), 32'd0);
      chk("rst_hrdata", bus.HRDATA, 32'd0);
      chk("rst_miss_cnt", 32'(bus.MISS_CNT), 32'd0);
      chk("rst_hsel_s", 32'(bus.HSEL_S), 32'b1000);
      chk("rst_hsel_def", 32'(bus.HSEL_DEF), 32'd0);
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;

      beat("s2_rd", 32'h0000_2004, NONSEQ, 2);
      beat("s1_seq", 32'h0000_1FFC, SEQ, 0);
      beat("miss", 32'h0000_8000, NONSEQ, 1);
      chk("miss_cnt_1", 32'(bus.MISS_CNT), 32'd1);
      beat("idle_unmapped", 32'h0000_8000, IDLE, 0);
      beat("busy_unmapped", 32'h0000_9000, BUSY, 0);
      chk("miss_cnt_idle", 32'(bus.MISS_CNT), 32'd1);
      beat("b2b_s0", 32'h0000_0040, NONSEQ, 1);
      beat("b2b_s3", 32'h0000_3010, NONSEQ, 0);
      beat("idle_s0", 32'h0000_0000, IDLE, 0);
      beat("err2", 32'h0001_0000, NONSEQ, 1);
      beat("idle_after_err", 32'h0000_0100, IDLE, 0);
      chk("miss_cnt_2", 32'(bus.MISS_CNT), 32'd2);

      for (int i = 0; i < 65533; i++) begin
         beat("sat", 32'h0040_0000, NONSEQ, 0);
         if (timed_out) break;
      end
      chk("miss_cnt_full", 32'(bus.MISS_CNT), 32'hFFFF);
      beat("sat_hold", 32'h0040_0000, NONSEQ, 1);
      chk("miss_cnt_sat", 32'(bus.MISS_CNT), 32'hFFFF);

      beat("pre_rst", 32'h0000_1000, NONSEQ, 6);
      have_addr  = 1'b0;
      bus.HTRANS = IDLE;
      bus.HADDR  = 32'h0000_8000;
      #2;
      HRESETn = 1'b0;
      #1;
      chk("midrst_hready", 32'(bus.HREADY), 32'd1);
      chk("midrst_hresp", 32'(bus.HRESP), 32'd0);
      chk("midrst_hrdata", bus.HRDATA, 32'd0);
      chk("midrst_miss_cnt", 32'(bus.MISS_CNT), 32'd0);
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;

      beat("post_rst_s3", 32'h0000_3000, NONSEQ, 1);
      beat("post_rst_miss", 32'h0000_5000, NONSEQ, 1);
      chk("miss_cnt_after_rst", 32'(bus.MISS_CNT), 32'd1);
      beat("drain", 32'h0000_8000, IDLE, 0);
      beat("drain2", 32'h0000_8000, IDLE, 0);

      chk("ovl_hsel_s", 32'(bus2.HSEL_S), 32'b0001);
      chk("ovl_hsel_def", 32'(bus2.HSEL_DEF), 32'd0);
      chk("ovl_hrdata", bus2.HRDATA, 32'h5050_0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
